// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master side is the loader; the slave side is the byte source plus imem.
interface imem_program_loader_if #(
   parameter int ADDR_W = 8,
   parameter int WORD_W = 32
);
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_wdata;

   modport master (
      input  byte_in, byte_valid,
      output byte_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output byte_in, byte_valid,
      input  byte_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_program_loader.sv
// Packs a big-endian byte stream into instruction words and writes them to imem while holding the CPU.
// Optional trailing checksum word is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_program_loader #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int WORD_W = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W:0]       word_count,
   imem_program_loader_if.master bus,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);
   localparam int                SHIFT_W  = WORD_W - 8;
   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

   state_t              state_reg, state_next;
   logic [1:0]          byte_cnt_reg, byte_cnt_next;
   logic [SHIFT_W-1:0]  shift_reg, shift_next;
   logic [WORD_W-1:0]   wdata_reg, wdata_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [ADDR_W:0]     words_reg, words_next;
   logic [ADDR_W:0]     count_reg, count_next;
   logic                hold_reg, hold_next;
   logic                done_reg, done_next;
   logic                error_reg, error_next;
   logic                accept;
   logic                start_illegal;
   logic [WORD_W-1:0]   assembled;
   logic [ADDR_W:0]     words_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [WORD_W-1:0]   sum_reg, sum_next;
   logic                chk_reg, chk_next;
`endif

   assign accept        = (state_reg == COLLECT) && bus.byte_valid;
   assign assembled     = {shift_reg, bus.byte_in};
   assign words_inc     = words_reg + CNT_ONE;
   assign start_illegal = (word_count == '0) || (word_count > DEPTH_C);

   assign bus.byte_ready = (state_reg == COLLECT);
   assign bus.imem_we    = (state_reg == WRITE);
   assign bus.imem_addr  = addr_reg;
   assign bus.imem_wdata = wdata_reg;
   assign cpu_hold       = hold_reg;
   assign done           = done_reg;
   assign error          = error_reg;

   always_comb begin
      state_next    = state_reg;
      byte_cnt_next = byte_cnt_reg;
      shift_next    = shift_reg;
      wdata_next    = wdata_reg;
      addr_next     = addr_reg;
      words_next    = words_reg;
      count_next    = count_reg;
      hold_next     = hold_reg;
      done_next     = done_reg;
      error_next    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_next      = sum_reg;
      chk_next      = chk_reg;
`endif
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               if (start_illegal) begin
                  error_next = 1'b1;
               end else begin
                  count_next    = word_count;
                  addr_next     = '0;
                  words_next    = '0;
                  byte_cnt_next = '0;
                  hold_next     = 1'b1;
                  done_next     = 1'b0;
                  state_next    = COLLECT;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  sum_next      = '0;
                  chk_next      = 1'b0;
`endif
               end
            end
         end
         COLLECT: begin
            if (accept) begin
               // 2-bit counter wraps to 0 on the fourth byte, ready for the next word
               shift_next    = assembled[SHIFT_W-1:0];
               byte_cnt_next = byte_cnt_reg + 2'd1;
               if (byte_cnt_reg == 2'd3) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  if (chk_reg) begin
                     if (assembled == sum_reg) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                        hold_next  = 1'b0;
                     end else begin
                        state_next = IDLE;
                        error_next = 1'b1;
                     end
                  end else begin
                     wdata_next = assembled;
                     state_next = WRITE;
                  end
`else
                  wdata_next = assembled;
                  state_next = WRITE;
`endif
               end
            end
         end
         WRITE: begin
            words_next = words_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_next   = sum_reg + wdata_reg;
`endif
            // The counter is one bit wider than the address, so a full-depth load ends at 256, not 0
            if (words_inc == count_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_next   = 1'b1;
               state_next = COLLECT;
`else
               state_next = DONE;
               done_next  = 1'b1;
               hold_next  = 1'b0;
`endif
            end else begin
               addr_next  = addr_reg + ADDR_ONE;
               state_next = COLLECT;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg    <= IDLE;
         byte_cnt_reg <= '0;
         shift_reg    <= '0;
         wdata_reg    <= '0;
         addr_reg     <= '0;
         words_reg    <= '0;
         count_reg    <= '0;
         hold_reg     <= 1'b1;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_reg      <= '0;
         chk_reg      <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         byte_cnt_reg <= byte_cnt_next;
         shift_reg    <= shift_next;
         wdata_reg    <= wdata_next;
         addr_reg     <= addr_next;
         words_reg    <= words_next;
         count_reg    <= count_next;
         hold_reg     <= hold_next;
         done_reg     <= done_next;
         error_reg    <= error_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_reg      <= sum_next;
         chk_reg      <= chk_next;
`endif
      end
   end
endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: a per-cycle vector table followed by
// hand-written stall, reset-mid-word, full-depth and checksum sequences.
module tb_imem_program_loader;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 256;
   localparam int WORD_W = 32;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W:0]   word_count = '0;
   logic              cpu_hold;
   logic              done;
   logic              error;

   imem_program_loader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

   imem_program_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        start;
      logic [8:0]  wc;
      logic        valid;
      logic [7:0]  bin;
      logic        rdy;
      logic        we;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic        hold;
      logic        dn;
      logic        err;
   } vec_t;

   vec_t        vecs[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [7:0]  byte_q[$];
   logic [7:0]  wa_q[$];
   logic [31:0] wd_q[$];
   int          rdy_we_viol = 0;
   int          err_pulses = 0;

   function automatic vec_t mk(logic s, logic [8:0] wc, logic v, logic [7:0] b, logic rdy,
                               logic we, logic [7:0] a, logic [31:0] d,
                               logic h, logic dn, logic e);
      vec_t r;
      r.start = s; r.wc = wc; r.valid = v; r.bin = b; r.rdy = rdy; r.we = we;
      r.addr = a; r.wdata = d; r.hold = h; r.dn = dn; r.err = e;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else pass_cnt++;
   endtask

   // Write log, one line per imem write
   always @(negedge clock) begin
      if (bus.imem_we === 1'b1) begin
         wa_q.push_back(bus.imem_addr);
         wd_q.push_back(bus.imem_wdata);
         $display("write addr=0x%02h data=0x%08h", bus.imem_addr, bus.imem_wdata);
         if (bus.byte_ready !== 1'b0) rdy_we_viol++;
      end
      if (error === 1'b1) err_pulses++;
   end

   // Called at a negedge; returns at a negedge after the last queued byte was accepted
   task automatic send_bytes(input bit toggle, input int budget);
      int n = 0;
      bit phase = 1'b0;
      while (byte_q.size() > 0) begin
         if (toggle && phase) begin
            bus.byte_valid = 1'b0;
         end else begin
            bus.byte_valid = 1'b1;
            bus.byte_in    = byte_q[0];
            if (bus.byte_ready === 1'b1) void'(byte_q.pop_front());
         end
         phase = !phase;
         @(negedge clock);
         n++;
         if (n > budget) begin
            total_cnt++;
            $display("FAIL send_timeout: got %0d bytes left, expected 0", byte_q.size());
            byte_q.delete();
         end
      end
      bus.byte_valid = 1'b0;
   endtask

   task automatic push_word(input logic [31:0] w);
      byte_q.push_back(w[31:24]);
      byte_q.push_back(w[23:16]);
      byte_q.push_back(w[15:8]);
      byte_q.push_back(w[7:0]);
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; bus.byte_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic start_load(input logic [8:0] wc);
      start = 1'b1; word_count = wc;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e0;
      bus.byte_in = '0;
      bus.byte_valid = 1'b0;

      // per-cycle table: outputs expected during the cycle in which the row's inputs are applied
      vecs.push_back(mk(1, 9'd0,   0, 8'h00, 0, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(1, 9'd257, 0, 8'h00, 0, 0, 8'h00, 32'h0,         1, 0, 1));
      vecs.push_back(mk(0, 9'd0,   0, 8'h00, 0, 0, 8'h00, 32'h0,         1, 0, 1));
      vecs.push_back(mk(1, 9'd2,   0, 8'h00, 0, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'h12, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(1, 9'd0,   1, 8'h34, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'h56, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'h78, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'h9A, 0, 1, 8'h00, 32'h12345678,  1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'h9A, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'hBC, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'hDE, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'hF0, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(1, 9'd0,   0, 8'h00, 0, 1, 8'h01, 32'h9ABCDEF0,  1, 0, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
      vecs.push_back(mk(0, 9'd0,   1, 8'hAC, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'hF1, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'h35, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   1, 8'h68, 1, 0, 8'h00, 32'h0,         1, 0, 0));
      vecs.push_back(mk(0, 9'd0,   0, 8'h00, 0, 0, 8'h00, 32'h0,         0, 1, 0));
`else
      vecs.push_back(mk(1, 9'd0,   1, 8'h55, 0, 0, 8'h00, 32'h0,         0, 1, 0));
      vecs.push_back(mk(0, 9'd0,   0, 8'h00, 0, 0, 8'h00, 32'h0,         0, 1, 1));
      vecs.push_back(mk(1, 9'd1,   0, 8'h00, 0, 0, 8'h00, 32'h0,         0, 1, 0));
      vecs.push_back(mk(0, 9'd0,   0, 8'h00, 1, 0, 8'h00, 32'h0,         1, 0, 0));
`endif

      // reset state
      repeat (2) @(negedge clock);
      chk("reset.byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("reset.imem_we",    32'(bus.imem_we),    32'd0);
      chk("reset.imem_addr",  32'(bus.imem_addr),  32'd0);
      chk("reset.imem_wdata", bus.imem_wdata,      32'd0);
      chk("reset.cpu_hold",   32'(cpu_hold),       32'd1);
      chk("reset.done",       32'(done),           32'd0);
      chk("reset.error",      32'(error),          32'd0);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         chk($sformatf("row%0d.byte_ready", i), 32'(bus.byte_ready), 32'(vecs[i].rdy));
         chk($sformatf("row%0d.imem_we", i),    32'(bus.imem_we),    32'(vecs[i].we));
         if (vecs[i].we) begin
            chk($sformatf("row%0d.imem_addr", i),  32'(bus.imem_addr), 32'(vecs[i].addr));
            chk($sformatf("row%0d.imem_wdata", i), bus.imem_wdata,     vecs[i].wdata);
         end
         chk($sformatf("row%0d.cpu_hold", i), 32'(cpu_hold), 32'(vecs[i].hold));
         chk($sformatf("row%0d.done", i),     32'(done),     32'(vecs[i].dn));
         chk($sformatf("row%0d.error", i),    32'(error),    32'(vecs[i].err));
         start          = vecs[i].start;
         word_count     = vecs[i].wc;
         bus.byte_valid = vecs[i].valid;
         bus.byte_in    = vecs[i].bin;
         @(negedge clock);
      end
      start = 1'b0;
      bus.byte_valid = 1'b0;

      // stalls: byte_valid toggling every cycle
      do_reset();
      wa_q.delete(); wd_q.delete(); rdy_we_viol = 0;
      start_load(9'd2);
      push_word(32'h12345678);
      push_word(32'h9ABCDEF0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      push_word(32'hACF13568);
`endif
      send_bytes(1'b1, 100);
      wait_cycles(3);
      chk("stall.write_count", 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2) begin
         chk("stall.addr0", 32'(wa_q[0]), 32'd0);
         chk("stall.data0", wd_q[0], 32'h12345678);
         chk("stall.addr1", 32'(wa_q[1]), 32'd1);
         chk("stall.data1", wd_q[1], 32'h9ABCDEF0);
      end
      chk("stall.ready_in_write", 32'(rdy_we_viol), 32'd0);
      chk("stall.done", 32'(done), 32'd1);
      chk("stall.cpu_hold", 32'(cpu_hold), 32'd0);

      // reset after two bytes of a word
      do_reset();
      start_load(9'd2);
      wa_q.delete(); wd_q.delete();
      byte_q.push_back(8'h12);
      byte_q.push_back(8'h34);
      send_bytes(1'b0, 20);
      do_reset();
      chk("rstmid.cpu_hold", 32'(cpu_hold), 32'd1);
      chk("rstmid.byte_ready", 32'(bus.byte_ready), 32'd0);
      start_load(9'd1);
      push_word(32'hAABBCCDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
      push_word(32'hAABBCCDD);
`endif
      send_bytes(1'b0, 40);
      wait_cycles(3);
      chk("rstmid.write_count", 32'(wa_q.size()), 32'd1);
      if (wa_q.size() == 1) begin
         chk("rstmid.addr0", 32'(wa_q[0]), 32'd0);
         chk("rstmid.data0", wd_q[0], 32'hAABBCCDD);
      end
      chk("rstmid.done", 32'(done), 32'd1);

      // full depth: word i = i
      do_reset();
      wa_q.delete(); wd_q.delete();
      start_load(9'd256);
      for (int i = 0; i < DEPTH; i++) push_word(32'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
      push_word(32'h00007F80);
`endif
      send_bytes(1'b0, 3000);
      wait_cycles(4);
      chk("full.write_count", 32'(wa_q.size()), 32'd256);
      begin
         int bad = 0;
         for (int i = 0; i < wa_q.size(); i++)
            if (wa_q[i] !== 8'(i) || wd_q[i] !== 32'(i)) bad++;
         chk("full.bad_entries", 32'(bad), 32'd0);
      end
      if (wa_q.size() > 0) chk("full.last_addr", 32'(wa_q[wa_q.size()-1]), 32'hFF);
      chk("full.done", 32'(done), 32'd1);
      chk("full.cpu_hold", 32'(cpu_hold), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // bad checksum
      do_reset();
      wa_q.delete(); wd_q.delete();
      e0 = err_pulses;
      start_load(9'd2);
      push_word(32'h12345678);
      push_word(32'h9ABCDEF0);
      push_word(32'h00000000);
      send_bytes(1'b0, 40);
      wait_cycles(3);
      chk("cksum.err_pulses", 32'(err_pulses - e0), 32'd1);
      chk("cksum.done", 32'(done), 32'd0);
      chk("cksum.cpu_hold", 32'(cpu_hold), 32'd1);
      chk("cksum.byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("cksum.write_count", 32'(wa_q.size()), 32'd2);
`else
      // illegal count from IDLE leaves the block idle with no writes
      do_reset();
      wa_q.delete(); wd_q.delete();
      e0 = err_pulses;
      start_load(9'd0);
      start_load(9'd257);
      wait_cycles(3);
      chk("illegal.err_pulses", 32'(err_pulses - e0), 32'd2);
      chk("illegal.write_count", 32'(wa_q.size()), 32'd0);
      chk("illegal.byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("illegal.cpu_hold", 32'(cpu_hold), 32'd1);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Loads a program image into instruction memory before the pipelined CPU runs.
- A byte stream arrives over a valid/ready handshake; the block packs four bytes into one 32-bit instruction word and drives the instruction-memory write port at sequential word addresses.
- It holds the CPU (cpu_hold) until the image is complete.
- It is the writer-side counterpart to the fetch stage, which reads imem at pc[7:0].

Parameters:
- ADDR_W, 8, instruction-memory word-address width (matches pc[7:0] fetch indexing).
- DEPTH, 256, instruction-memory depth in words; must equal 2**ADDR_W.
- WORD_W, 32, instruction word width; fixed at 4 bytes.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- word_count  input  ADDR_W+1  number of words to load, sampled on start; legal range 1..DEPTH.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write enable, one cycle per word.
- imem_addr  output  ADDR_W  write word address.
- imem_wdata  output  WORD_W  write data.
- cpu_hold  output  1  keeps CPU/PC in reset while high.
- done  output  1  load complete; level output.
- error  output  1  one-cycle pulse on an illegal request or checksum failure.

Behaviour:
- Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0. The byte counter, word counter and shift register are all cleared.
- Reset mid-load aborts immediately.
  - The partial word is discarded; no write is issued for it.
  - Words already written stay in memory.
  - cpu_hold returns to 1.
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE / DONE on start:
  - word_count of 0 or greater than DEPTH: error pulses for 1 cycle, state is unchanged, no write occurs.
  - Legal word_count: latch it, clear the address and byte counter, set cpu_hold=1 and done=0, then go to COLLECT.
- COLLECT:
  - byte_ready=1.
  - A byte is accepted only when byte_valid && byte_ready.
  - Byte order is big-endian: the first accepted byte becomes bits [31:24], so the opcode nibble arrives first.
  - On acceptance of the 4th byte, go to WRITE next cycle.
  - When byte_valid=0 the loader simply waits; there is no timeout.
- WRITE (1 cycle):
  - byte_ready=0, imem_we=1, imem_addr=current word index, imem_wdata=assembled word.
  - Latency: 4th byte accepted at edge N; imem_we is high during cycle N+1; all write outputs are registered.
  - Next edge: if words written equals word_count, go to DONE; otherwise increment imem_addr and return to COLLECT.
- DONE: done=1, cpu_hold=0, byte_ready=0. A new legal start re-enters a load and reasserts cpu_hold in the next cycle.
- Address wrap: with word_count=DEPTH, the last write is at address DEPTH-1. The internal counter is ADDR_W+1 bits wide, so the completion compare never aliases to 0.
- start asserted in COLLECT or WRITE is ignored.
- byte_valid held high with data in WRITE, IDLE or DONE: no byte is consumed.
- imem_we is never high outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last program word, COLLECT takes one extra 4-byte big-endian word. It is not written to imem.
  - This word is compared to the mod-2^32 sum of all written words.
  - Match: go to DONE as normal.
  - Mismatch: error pulses 1 cycle, state returns to IDLE, cpu_hold stays 1, done stays 0.
- Not defined: no extra word is expected; the DONE transition follows the last WRITE directly.

Test Plan:
- Basic load:
  - Stimulus: reset, then start with word_count=2, then bytes 12 34 56 78 9A BC DE F0 streamed back-to-back.
  - Response: imem_we at addr 0 with data 0x12345678, then addr 1 with data 0x9ABCDEF0. done=1 and cpu_hold=0 one cycle after the second write.
- Stalls:
  - Stimulus: the same image with byte_valid toggling 1/0 every cycle.
  - Response: identical writes and data. No byte is lost or duplicated, and byte_ready=0 during each WRITE cycle.
- Full depth:
  - Stimulus: word_count=256, word i = i.
  - Response: 256 writes at addresses 0x00..0xFF with matching data; the last address is 0xFF and no 257th write occurs; then done=1.
- Illegal counts:
  - Stimulus: start with word_count=0, then with 257.
  - Response: one error pulse each, imem_we never asserted, state stays IDLE, cpu_hold=1.
- Reset mid-word:
  - Stimulus: after 2 of 4 bytes, assert reset for 1 cycle; then start with word_count=1 and send AA BB CC DD.
  - Response: no write for the partial word; a single write at addr 0 with data 0xAABBCCDD.
- Checksum (IMEM_LOADER_CHECKSUM_EN defined):
  - Stimulus: 2 words, checksum word 0xACF13568.
  - Response: done=1.
  - Stimulus: same words, checksum 0x00000000.
  - Response: error pulse, done=0, cpu_hold=1.
